stereo_level_meter: RTL and testbench
=====================================

Name: stereo_level_meter

Overview:
- Upstream stage of the Nios system. Turns a stream of 12-bit ADC samples, alternating left/right, into windowed 32-bit level values.
- Level outputs drive adc_links_pio_export and adc_rechts_pio_export.
- status drives adc_data_pio_in_port; freeze/clear come from adc_data_pio_out_port.
- The visualizer firmware reads stable per-window levels instead of raw samples.

Parameters:
- SAMPLE_W, 12, ADC sample width (unsigned, offset binary).
- MIDSCALE, 2048, zero-signal code subtracted before magnitude.
- WINDOW_LOG2, 10, window length = 2^WINDOW_LOG2 left/right pairs.
- OUT_W, 32, level output width; accumulators saturate at 2^OUT_W-1.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous active-high reset
- smp_valid  in  1  sample present
- smp_ready  out  1  block accepts sample this cycle
- smp_chan  in  1  0 = left (links), 1 = right (rechts)
- smp_data  in  SAMPLE_W  ADC code
- freeze  in  1  hold published levels (adc_data_pio_out_port[0])
- clear  in  1  discard partial window (adc_data_pio_out_port[1])
- links_level  out  OUT_W  published left level
- rechts_level  out  OUT_W  published right level
- level_update  out  1  one-cycle pulse when levels change
- status  out  6  [0] result_valid, [1] overflow sticky, [2] seq_err sticky, [5:3] window count mod 8

Behaviour:
- Interface: one clock, clk_clk; reset_reset is synchronous and active-high.
- Reset: all outputs, accumulators, pair counter, FSM (to ACCUM) and sticky bits are 0. Reset mid-window discards the partial window; no update pulse is issued.
- Handshake: a sample is accepted when smp_valid & smp_ready. smp_ready = (state==ACCUM) & ~clear.
- Magnitude: mag = |smp_data - MIDSCALE|, SAMPLE_W bits. mag is added to the left or right accumulator.
- Saturation: an accumulator saturates at 2^OUT_W-1. Any saturating add sets overflow (status[1]).
- Expected channel starts at left and toggles on each correctly ordered accept.
- A sample whose smp_chan differs from the expected channel is still accepted (ready held) but discarded, and sets seq_err (status[2]). The expected channel does not change.
- Pair counter increments on each accepted right sample.
- When the right sample completing pair 2^WINDOW_LOG2 is accepted in cycle N, the FSM enters PUBLISH in cycle N+1; smp_ready=0 there.
- At the edge ending PUBLISH:
  - freeze=0: links_level/rechts_level take the accumulator values; level_update=1 for exactly one cycle (N+2); result_valid is set; window count increments, wrapping 7->0.
  - freeze=1: outputs, window count and result_valid are unchanged; no pulse.
  - In both cases, accumulators and the pair counter are zeroed and the FSM returns to ACCUM.
- Latency: last sample accepted at N -> new levels visible and pulse at N+2.
- clear=1 (any state):
  - zeros accumulators, pair counter and expected channel;
  - clears overflow and seq_err;
  - forces the FSM to ACCUM;
  - keeps published levels, result_valid and window count.
  - clear wins over a simultaneous sample (not accepted) and over PUBLISH (no update).
- Accumulator and level values are unsigned; no rounding.

Optional Feature:
- Macro: STEREO_LEVEL_PEAK_DECAY_EN.
- Defined: at publish (freeze=0), each channel's new level = max(window_sum, old_level - (old_level >> 3)). Gives a fall-off meter; 0 stays 0. level_update still pulses every publish.
- Undefined: level = window_sum exactly, as above.

Test Plan:
- WINDOW_LOG2=2. 4 pairs, L=2148, R=1998 -> links_level=400, rechts_level=200. Single level_update 2 cycles after the 4th R accept; status=6'b001001.
- WINDOW_LOG2=2, OUT_W=12. 4 pairs L=0, R=4095 -> links_level=4095 (saturated), rechts_level=8188 capped at 4095; status[1]=1. Then clear -> status[1]=0 and levels held at 4095.
- Send L, L, R, then 3 correct pairs of L=2058/R=2048 -> second L discarded; seq_err=1; links_level=40, rechts_level=0.
- freeze=1 over a full window of L=3048 -> levels stay at prior values, no pulse, window count unchanged. freeze=0 next window -> update pulse.
- clear asserted in the same cycle as the 3rd pair's L with smp_valid=1 -> smp_ready=0 and sample not taken. The next 4 pairs produce a window from those samples only.
- Reset after 2 pairs -> all outputs 0 next cycle; 4 fresh pairs give a correct first window. With PEAK_DECAY_EN: levels 800 then window sum 0 -> 700, then 613.

Source files
------------

// File: rtl/stereo_level_meter.sv
// Stereo ADC level meter: accumulates |sample - MIDSCALE| per channel over a window of
// 2^WINDOW_LOG2 left/right pairs and publishes the sums. Define STEREO_LEVEL_PEAK_DECAY_EN for fall-off levels.
module stereo_level_meter #(
   parameter int SAMPLE_W    = 12,
   parameter int MIDSCALE    = 2048,
   parameter int WINDOW_LOG2 = 10,
   parameter int OUT_W       = 32
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic                smp_valid,
   output logic                smp_ready,
   input  logic                smp_chan,
   input  logic [SAMPLE_W-1:0] smp_data,
   input  logic                freeze,
   input  logic                clear,
   output logic [OUT_W-1:0]    links_level,
   output logic [OUT_W-1:0]    rechts_level,
   output logic                level_update,
   output logic [5:0]          status
);

   typedef enum logic {ACCUM = 1'b0, PUBLISH = 1'b1} state_t;

   localparam logic [SAMPLE_W-1:0]    MID       = SAMPLE_W'(MIDSCALE);
   localparam logic [WINDOW_LOG2-1:0] PAIR_LAST = '1;
   localparam logic [OUT_W-1:0]       SAT_MAX   = '1;

   state_t                 state, state_next;
   logic [OUT_W-1:0]       links_acc, rechts_acc;
   logic [OUT_W-1:0]       links_pub, rechts_pub;
   logic [WINDOW_LOG2-1:0] pair_cnt;
   logic                   exp_chan;
   logic                   result_valid, overflow, seq_err;
   logic [2:0]             win_cnt;
   logic [SAMPLE_W-1:0]    mag;
   logic [OUT_W:0]         links_sum, rechts_sum;
   logic                   accept, in_order;

`ifdef STEREO_LEVEL_PEAK_DECAY_EN
   // Level falls by 1/8 per window unless the new window sum is larger.
   function automatic logic [OUT_W-1:0] peak_decay(input logic [OUT_W-1:0] old_level,
                                                   input logic [OUT_W-1:0] window_sum);
      logic [OUT_W-1:0] decayed;
      decayed = old_level - (old_level >> 3);
      return (window_sum > decayed) ? window_sum : decayed;
   endfunction
`endif

   assign smp_ready  = (state == ACCUM) && !clear;
   assign accept     = smp_valid && smp_ready;
   assign in_order   = (smp_chan == exp_chan);
   assign mag        = (smp_data >= MID) ? (smp_data - MID) : (MID - smp_data);
   assign links_sum  = {1'b0, links_acc} + (OUT_W+1)'(mag);
   assign rechts_sum = {1'b0, rechts_acc} + (OUT_W+1)'(mag);
   assign status     = {win_cnt, seq_err, overflow, result_valid};

   always_comb begin
      state_next = state;
      links_pub  = links_acc;
      rechts_pub = rechts_acc;
`ifdef STEREO_LEVEL_PEAK_DECAY_EN
      links_pub  = peak_decay(links_level, links_acc);
      rechts_pub = peak_decay(rechts_level, rechts_acc);
`endif
      case (state)
         ACCUM:   if (accept && in_order && smp_chan && (pair_cnt == PAIR_LAST))
                     state_next = PUBLISH;
         PUBLISH: state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
      if (clear)
         state_next = ACCUM;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset)
         state <= ACCUM;
      else
         state <= state_next;
   end

   // Clear drops the partial window and sticky errors but keeps what has been published.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         links_acc    <= '0;
         rechts_acc   <= '0;
         pair_cnt     <= '0;
         exp_chan     <= 1'b0;
         overflow     <= 1'b0;
         seq_err      <= 1'b0;
         links_level  <= '0;
         rechts_level <= '0;
         level_update <= 1'b0;
         result_valid <= 1'b0;
         win_cnt      <= '0;
      end else if (clear) begin
         links_acc    <= '0;
         rechts_acc   <= '0;
         pair_cnt     <= '0;
         exp_chan     <= 1'b0;
         overflow     <= 1'b0;
         seq_err      <= 1'b0;
         level_update <= 1'b0;
      end else begin
         level_update <= 1'b0;
         if (state == PUBLISH) begin
            if (!freeze) begin
               links_level  <= links_pub;
               rechts_level <= rechts_pub;
               level_update <= 1'b1;
               result_valid <= 1'b1;
               win_cnt      <= win_cnt + 3'd1;
            end
            links_acc  <= '0;
            rechts_acc <= '0;
            pair_cnt   <= '0;
            exp_chan   <= 1'b0;
         end else if (accept) begin
            if (!in_order) begin
               seq_err <= 1'b1;
            end else if (!smp_chan) begin
               links_acc <= links_sum[OUT_W] ? SAT_MAX : links_sum[OUT_W-1:0];
               if (links_sum[OUT_W])
                  overflow <= 1'b1;
               exp_chan <= 1'b1;
            end else begin
               rechts_acc <= rechts_sum[OUT_W] ? SAT_MAX : rechts_sum[OUT_W-1:0];
               if (rechts_sum[OUT_W])
                  overflow <= 1'b1;
               pair_cnt <= pair_cnt + 1'b1;
               exp_chan <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_stereo_level_meter.sv
// Directed self-checking bench for stereo_level_meter with a 4-pair window and 12-bit levels.
module tb_stereo_level_meter;

   logic        clk_clk = 1'b0;
   logic        reset_reset = 1'b1;
   logic        smp_valid = 1'b0;
   logic        smp_ready;
   logic        smp_chan = 1'b0;
   logic [11:0] smp_data = 12'd2048;
   logic        freeze = 1'b0;
   logic        clear = 1'b0;
   logic [11:0] links_level, rechts_level;
   logic        level_update;
   logic [5:0]  status;

   int checks = 0;
   int failures = 0;
   logic [11:0] exp_l = '0;
   logic [11:0] exp_r = '0;

   stereo_level_meter #(
      .SAMPLE_W(12), .MIDSCALE(2048), .WINDOW_LOG2(2), .OUT_W(12)
   ) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_chan(smp_chan), .smp_data(smp_data),
      .freeze(freeze), .clear(clear),
      .links_level(links_level), .rechts_level(rechts_level),
      .level_update(level_update), .status(status)
   );

   always #5 clk_clk = ~clk_clk;

   // Published level for a window sum, given the previously published level.
   function automatic logic [11:0] pub(input logic [11:0] old_level, input logic [11:0] window_sum);
`ifdef STEREO_LEVEL_PEAK_DECAY_EN
      logic [11:0] decayed;
      decayed = old_level - (old_level >> 3);
      return (window_sum > decayed) ? window_sum : decayed;
`else
      return window_sum;
`endif
   endfunction

   task automatic applyStimulus(input logic v, input logic ch, input logic [11:0] d);
      smp_valid = v;
      smp_chan  = ch;
      smp_data  = d;
      @(posedge clk_clk);
      #1;
      smp_valid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic sendPairs(input int n, input logic [11:0] l, input logic [11:0] r);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, 1'b0, l);
         applyStimulus(1'b1, 1'b1, r);
      end
   endtask

   // Last right sample was just accepted: one PUBLISH cycle, then levels and pulse.
   task automatic checkPublish(input string tag, input logic pulse, input logic [5:0] st);
      checkOutput({tag, "_ready_in_publish"}, smp_ready, 1'b0);
      checkOutput({tag, "_no_early_pulse"}, level_update, 1'b0);
      applyStimulus(1'b0, 1'b0, 12'd2048);
      checkOutput({tag, "_pulse"}, level_update, pulse);
      checkOutput({tag, "_links"}, links_level, exp_l);
      checkOutput({tag, "_rechts"}, rechts_level, exp_r);
      checkOutput({tag, "_status"}, status, st);
      applyStimulus(1'b0, 1'b0, 12'd2048);
      checkOutput({tag, "_pulse_one_cycle"}, level_update, 1'b0);
   endtask

   initial begin
      // Reset state
      applyStimulus(1'b0, 1'b0, 12'd2048);
      applyStimulus(1'b0, 1'b0, 12'd2048);
      reset_reset = 1'b0;
      checkOutput("reset_links", links_level, 12'd0);
      checkOutput("reset_rechts", rechts_level, 12'd0);
      checkOutput("reset_status", status, 6'd0);
      checkOutput("reset_pulse", level_update, 1'b0);
      checkOutput("reset_ready", smp_ready, 1'b1);

      // Basic window: |2148-2048|*4 = 400, |1998-2048|*4 = 200
      sendPairs(4, 12'd2148, 12'd1998);
      exp_l = pub(exp_l, 12'd400);
      exp_r = pub(exp_r, 12'd200);
      checkPublish("basic", 1'b1, 6'b001001);

      // Out-of-order left is discarded: 4 accepted lefts of 10, rights of 0
      applyStimulus(1'b1, 1'b0, 12'd2058);
      applyStimulus(1'b1, 1'b0, 12'd2058);
      checkOutput("seq_err_sticky_now", status[2], 1'b1);
      applyStimulus(1'b1, 1'b1, 12'd2048);
      sendPairs(3, 12'd2058, 12'd2048);
      exp_l = pub(exp_l, 12'd40);
      exp_r = pub(exp_r, 12'd0);
      checkPublish("seqerr", 1'b1, 6'b010101);
      clear = 1'b1;
      applyStimulus(1'b0, 1'b0, 12'd2048);
      clear = 1'b0;
      checkOutput("seqerr_clear_status", status, 6'b010001);
      checkOutput("seqerr_clear_links_held", links_level, exp_l);

      // Saturation at 4095 on both channels
      sendPairs(4, 12'd0, 12'd4095);
      exp_l = pub(exp_l, 12'd4095);
      exp_r = pub(exp_r, 12'd4095);
      checkPublish("sat", 1'b1, 6'b011011);
      clear = 1'b1;
      applyStimulus(1'b0, 1'b0, 12'd2048);
      clear = 1'b0;
      checkOutput("sat_clear_status", status, 6'b011001);
      checkOutput("sat_clear_links_held", links_level, 12'd4095);
      checkOutput("sat_clear_rechts_held", rechts_level, 12'd4095);

      // Frozen window publishes nothing; next window does
      freeze = 1'b1;
      sendPairs(4, 12'd3048, 12'd2048);
      checkPublish("freeze", 1'b0, 6'b011001);
      freeze = 1'b0;
      sendPairs(4, 12'd2148, 12'd2148);
      exp_l = pub(exp_l, 12'd400);
      exp_r = pub(exp_r, 12'd400);
      checkPublish("unfreeze", 1'b1, 6'b100001);

      // Clear mid-window blocks the coincident sample and drops the partial sums
      sendPairs(2, 12'd3048, 12'd3048);
      clear     = 1'b1;
      smp_valid = 1'b1;
      smp_chan  = 1'b0;
      smp_data  = 12'd3048;
      #1;
      checkOutput("clear_blocks_ready", smp_ready, 1'b0);
      applyStimulus(1'b1, 1'b0, 12'd3048);
      clear = 1'b0;
      sendPairs(3, 12'd2068, 12'd2058);
      checkOutput("clear_no_early_publish", smp_ready, 1'b1);
      sendPairs(1, 12'd2068, 12'd2058);
      exp_l = pub(exp_l, 12'd80);
      exp_r = pub(exp_r, 12'd40);
      checkPublish("clearwin", 1'b1, 6'b101001);

      // Reset mid-window, then a fresh first window and decay behaviour
      sendPairs(2, 12'd2248, 12'd2248);
      reset_reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 12'd2048);
      reset_reset = 1'b0;
      checkOutput("midreset_links", links_level, 12'd0);
      checkOutput("midreset_rechts", rechts_level, 12'd0);
      checkOutput("midreset_status", status, 6'd0);
      checkOutput("midreset_pulse", level_update, 1'b0);
      exp_l = '0;
      exp_r = '0;
      sendPairs(4, 12'd2248, 12'd2048);
      exp_l = pub(exp_l, 12'd800);
      exp_r = pub(exp_r, 12'd0);
      checkOutput("fresh_expect_800", exp_l, 12'd800);
      checkPublish("fresh", 1'b1, 6'b001001);
      sendPairs(4, 12'd2048, 12'd2048);
`ifdef STEREO_LEVEL_PEAK_DECAY_EN
      exp_l = 12'd700;
`else
      exp_l = 12'd0;
`endif
      checkPublish("decay1", 1'b1, 6'b010001);
      sendPairs(4, 12'd2048, 12'd2048);
`ifdef STEREO_LEVEL_PEAK_DECAY_EN
      exp_l = 12'd613;
`else
      exp_l = 12'd0;
`endif
      checkPublish("decay2", 1'b1, 6'b011001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
